// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 8 blocks of 4 words, refilled as whole
// 128-bit lines from instruction memory through a MEM_READ/MEM_BUSYWAIT handshake.
module instruction_cache #(
   parameter int ADDR_BITS  = 10,
   parameter int INDEX_BITS = 3
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   READ,
   input  logic [ADDR_BITS-1:0]   ADDRESS,
   output logic [31:0]            INSTRUCTION,
   output logic                   BUSYWAIT,
   output logic                   MEM_READ,
   output logic [ADDR_BITS-5:0]   MEM_ADDRESS,
   input  logic [127:0]           MEM_READDATA,
   input  logic                   MEM_BUSYWAIT
);

   localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS - 4;
   localparam int NUM_BLOCKS = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_READ = 2'd1,
      S_FILL     = 2'd2
   } state_t;

   state_t                  state_r, state_next_s;
   logic [NUM_BLOCKS-1:0]   valid_r;
   logic [TAG_BITS-1:0]     tag_r  [NUM_BLOCKS];
   logic [127:0]            data_r [NUM_BLOCKS];
   logic [TAG_BITS-1:0]     req_tag_r;
   logic [INDEX_BITS-1:0]   req_index_r;

   logic [TAG_BITS-1:0]     addr_tag_s;
   logic [INDEX_BITS-1:0]   addr_index_s;
   logic [1:0]              addr_word_s;
   logic                    hit_s;
   logic                    miss_s;
   logic                    fill_en_s;
   logic [127:0]            line_s;

   assign addr_tag_s   = ADDRESS[ADDR_BITS-1 -: TAG_BITS];
   assign addr_index_s = ADDRESS[INDEX_BITS+3:4];
   assign addr_word_s  = ADDRESS[3:2];

   // Lookup, miss detection and the fill strobe; a response arriving with RESET is dropped
   always_comb begin
      line_s    = data_r[addr_index_s];
      hit_s     = (state_r == S_IDLE) && valid_r[addr_index_s] && (tag_r[addr_index_s] == addr_tag_s);
      miss_s    = (state_r == S_IDLE) && READ && !hit_s;
      fill_en_s = (state_r == S_MEM_READ) && !MEM_BUSYWAIT && !RESET;
   end

   // Next-state logic and the combinational outputs to CPU and memory
   always_comb begin
      state_next_s = state_r;
      INSTRUCTION  = 32'h0000_0000;
      BUSYWAIT     = 1'b0;
      MEM_READ     = 1'b0;
      MEM_ADDRESS  = {(ADDR_BITS-4){1'b0}};
      case (state_r)
         S_IDLE: begin
            if (hit_s) begin
               case (addr_word_s)
                  2'd0:    INSTRUCTION = line_s[31:0];
                  2'd1:    INSTRUCTION = line_s[63:32];
                  2'd2:    INSTRUCTION = line_s[95:64];
                  2'd3:    INSTRUCTION = line_s[127:96];
                  default: INSTRUCTION = 32'h0000_0000;
               endcase
            end else begin
               INSTRUCTION = 32'h0000_0000;
            end
            if (miss_s) begin
               BUSYWAIT     = 1'b1;
               state_next_s = S_MEM_READ;
            end else begin
               BUSYWAIT     = 1'b0;
               state_next_s = S_IDLE;
            end
         end
         S_MEM_READ: begin
            BUSYWAIT    = 1'b1;
            MEM_READ    = 1'b1;
            MEM_ADDRESS = {req_tag_r, req_index_r};
            if (!MEM_BUSYWAIT) begin
               state_next_s = S_FILL;
            end else begin
               state_next_s = S_MEM_READ;
            end
         end
         S_FILL: begin
            BUSYWAIT     = 1'b1;
            state_next_s = S_IDLE;
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
      if (RESET) begin
         BUSYWAIT = 1'b0;
      end else begin
         BUSYWAIT = BUSYWAIT;
      end
   end

   // State, valid bits and the latched miss request
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r     <= S_IDLE;
         valid_r     <= {NUM_BLOCKS{1'b0}};
         req_tag_r   <= {TAG_BITS{1'b0}};
         req_index_r <= {INDEX_BITS{1'b0}};
      end else begin
         state_r <= state_next_s;
         if (miss_s) begin
            req_tag_r   <= addr_tag_s;
            req_index_r <= addr_index_s;
         end
         if (fill_en_s) begin
            valid_r[req_index_r] <= 1'b1;
         end
      end
   end

   // Tag and data arrays keep their contents across reset; only valid bits gate them
   always_ff @(posedge CLK) begin
      if (fill_en_s) begin
         tag_r[req_index_r]  <= req_tag_r;
         data_r[req_index_r] <= MEM_READDATA;
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: a vector table for single-cycle hit/idle cases
// plus hand-written miss, reset-mid-miss and zero-wait sequences against a small memory model.
module tb_instruction_cache;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          READ;
   logic [9:0]    ADDRESS;
   logic [31:0]   INSTRUCTION;
   logic          BUSYWAIT;
   logic          MEM_READ;
   logic [5:0]    MEM_ADDRESS;
   logic [127:0]  MEM_READDATA;
   logic          MEM_BUSYWAIT;

   int checks = 0;
   int errors = 0;
   int mem_waits = 2;
   int wait_cnt = 0;

   instruction_cache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .READ         (READ),
      .ADDRESS      (ADDRESS),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   // Memory model: line 0 is {D,C,B,A}; other lines carry their block address and word number
   function automatic logic [127:0] line_of(input logic [5:0] a);
      logic [127:0] l;
      if (a == 6'h00) begin
         l = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
      end else begin
         for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = {16'hC0DE, 2'b00, a, k[7:0]};
         end
      end
      return l;
   endfunction

   always @(posedge CLK) wait_cnt <= MEM_READ ? wait_cnt + 1 : 0;
   assign MEM_BUSYWAIT = (wait_cnt < mem_waits);
   assign MEM_READDATA = line_of(MEM_ADDRESS);

   typedef struct {
      int          grp;
      logic        read;
      logic [9:0]  addr;
      logic        exp_busy;
      logic        exp_mem_read;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Entered at a negedge; each vector occupies one cycle
   task automatic apply_group(input int g);
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].grp == g) begin
            READ = vecs[i].read;
            ADDRESS = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d busywait", i), {31'd0, BUSYWAIT}, {31'd0, vecs[i].exp_busy});
            chk($sformatf("vec%0d mem_read", i), {31'd0, MEM_READ}, {31'd0, vecs[i].exp_mem_read});
            chk($sformatf("vec%0d instruction", i), INSTRUCTION, vecs[i].exp_instr);
            @(negedge CLK);
         end
      end
   endtask

   // Full miss: entered at a negedge, leaves at the negedge after the first hit cycle
   task automatic miss(input string nm, input logic [9:0] a, input logic [5:0] ma,
                       input int w, input logic [31:0] instr);
      int n, mrc, first_mr;
      logic addr_ok;
      mem_waits = w;
      READ = 1'b1;
      ADDRESS = a;
      #1;
      chk({nm, " busywait same cycle"}, {31'd0, BUSYWAIT}, 32'd1);
      chk({nm, " no mem_read in miss cycle"}, {31'd0, MEM_READ}, 32'd0);
      n = 0; mrc = 0; first_mr = 0; addr_ok = 1'b1;
      while (BUSYWAIT && n < 20) begin
         n++;
         if (MEM_READ) begin
            mrc++;
            if (first_mr == 0) first_mr = n;
            if (MEM_ADDRESS !== ma) addr_ok = 1'b0;
         end
         @(negedge CLK);
         #1;
      end
      chk({nm, " busywait cycles"}, n, w + 3);
      chk({nm, " mem_read cycles"}, mrc, w + 1);
      chk({nm, " mem_read starts 2nd cycle"}, first_mr, 2);
      chk({nm, " mem_address"}, {31'd0, addr_ok}, 32'd1);
      chk({nm, " instruction after fill"}, INSTRUCTION, instr);
      chk({nm, " mem_read low after fill"}, {31'd0, MEM_READ}, 32'd0);
      @(negedge CLK);
   endtask

   initial begin
      vecs[0]  = '{1, 1'b1, 10'h004, 1'b0, 1'b0, 32'h0000_000B};
      vecs[1]  = '{1, 1'b1, 10'h008, 1'b0, 1'b0, 32'h0000_000C};
      vecs[2]  = '{1, 1'b1, 10'h00C, 1'b0, 1'b0, 32'h0000_000D};
      vecs[3]  = '{1, 1'b1, 10'h000, 1'b0, 1'b0, 32'h0000_000A};
      vecs[4]  = '{2, 1'b0, 10'h3F0, 1'b0, 1'b0, 32'h0000_0000};
      vecs[5]  = '{2, 1'b0, 10'h3F0, 1'b0, 1'b0, 32'h0000_0000};
      vecs[6]  = '{2, 1'b0, 10'h080, 1'b0, 1'b0, 32'h0000_0000};
      vecs[7]  = '{2, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_000A};
      vecs[8]  = '{3, 1'b1, 10'h154, 1'b0, 1'b0, 32'hC0DE_1501};
      vecs[9]  = '{3, 1'b1, 10'h15C, 1'b0, 1'b0, 32'hC0DE_1503};
      vecs[10] = '{3, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_000A};
      vecs[11] = '{3, 1'b1, 10'h150, 1'b0, 1'b0, 32'hC0DE_1500};

      RESET = 1'b1;
      READ = 1'b1;
      ADDRESS = 10'h000;
      @(negedge CLK);
      #1;
      chk("reset busywait", {31'd0, BUSYWAIT}, 32'd0);
      chk("reset mem_read", {31'd0, MEM_READ}, 32'd0);
      chk("reset mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
      chk("reset instruction", INSTRUCTION, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;

      // Cold miss, then sequential hits
      miss("cold", 10'h000, 6'h00, 2, 32'h0000_000A);
      apply_group(1);

      // Conflict miss on index 0 and the evicting re-access
      miss("conflict", 10'h080, 6'h08, 2, 32'hC0DE_0800);
      miss("reaccess", 10'h000, 6'h00, 2, 32'h0000_000A);

      // READ=0 lookups never start a miss
      apply_group(2);

      // Reset during the second MEM_READ cycle of a miss on 10'h0C0
      mem_waits = 2;
      READ = 1'b1;
      ADDRESS = 10'h0C0;
      @(negedge CLK);
      #1;
      chk("rst-mid mem_read first", {31'd0, MEM_READ}, 32'd1);
      chk("rst-mid mem_address", {26'd0, MEM_ADDRESS}, 32'h0C);
      @(negedge CLK);
      RESET = 1'b1;
      READ = 1'b0;
      #1;
      chk("rst-mid mem_read 2nd cycle", {31'd0, MEM_READ}, 32'd1);
      chk("rst-mid busywait forced low", {31'd0, BUSYWAIT}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      chk("rst-mid mem_read dropped", {31'd0, MEM_READ}, 32'd0);
      chk("rst-mid idle busywait", {31'd0, BUSYWAIT}, 32'd0);
      chk("rst-mid late response seen", {31'd0, MEM_BUSYWAIT}, 32'd0);
      @(negedge CLK);
      ADDRESS = 10'h0C0;
      #1;
      chk("rst-mid line not filled", INSTRUCTION, 32'd0);
      @(negedge CLK);
      ADDRESS = 10'h000;
      #1;
      chk("rst-mid valid cleared", INSTRUCTION, 32'd0);
      @(negedge CLK);
      miss("post-reset", 10'h000, 6'h00, 2, 32'h0000_000A);

      // Zero-wait memory
      miss("zero-wait", 10'h150, 6'h15, 0, 32'hC0DE_1500);
      apply_group(3);

      READ = 1'b0;
      @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
